// File: rtl/weight_sched_ctrl.sv
// Weight scheduling controller: derives systolic buffer geometry from the layer
// configuration, then strobes the weight address generator over every buffer element.
module weight_sched_ctrl #(
  parameter  int S2P = 8,
  parameter  int KW  = 4,
  parameter  int CW  = 10,
  parameter  int NW  = 10,
  parameter  int TW  = 12,
  localparam int RW  = $clog2(S2P),
  localparam int PW  = 2*KW + CW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [KW-1:0] kernel_size,
  input  logic [CW-1:0] channels,
  input  logic [NW-1:0] kernel_nums,
  input  logic [TW-1:0] img_tiles,
  input  logic          buf_ready,
  output logic          addr_enable,
  output logic          tensor_done,
  output logic [PW-1:0] buffer_col_nums,
  output logic [NW-1:0] buffer_row_nums,
  output logic [PW-1:0] img2col_w_width,
  output logic [RW-1:0] kernel_nums_rem,
  output logic [RW-1:0] img2col_w_width_rem,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, CALC1, CALC2, RUN, DONE} state_t;

  state_t state, next_state;

  logic [KW-1:0]   k_q;
  logic [CW-1:0]   c_q;
  logic [NW-1:0]   n_q;
  logic [TW-1:0]   tiles_q;
  logic [PW-1:0]   kkc_q;
  logic [2*RW-1:0] elem_cnt;
  logic [PW-1:0]   col_cnt;
  logic [TW-1:0]   pass_cnt;
  logic [NW-1:0]   row_cnt;

  logic elem_max, col_max, pass_max, row_max, last_strobe, cfg_zero;

  // S2P is a power of two, so the innermost maximum is simply all ones
  assign elem_max    = &elem_cnt;
  assign col_max     = (col_cnt  == buffer_col_nums - PW'(1));
  assign pass_max    = (pass_cnt == tiles_q - TW'(1));
  assign row_max     = (row_cnt  == buffer_row_nums - NW'(1));
  assign last_strobe = elem_max && col_max && pass_max && row_max;
  assign cfg_zero    = (k_q == '0) || (c_q == '0) || (n_q == '0) || (tiles_q == '0);
  assign tensor_done = (state == RUN) && pass_max;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    done        = 1'b0;
    addr_enable = 1'b0;
    case (state)
      IDLE:  if (start) next_state = CALC1;
      CALC1: begin
        busy       = 1'b1;
        next_state = CALC2;
      end
      CALC2: begin
        busy       = 1'b1;
        next_state = cfg_zero ? DONE : RUN;
      end
      RUN: begin
        busy        = 1'b1;
        addr_enable = buf_ready;
        if (buf_ready && last_strobe) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Ceiling division and remainders reduce to shifts and low-bit masks
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_q                 <= '0;
      c_q                 <= '0;
      n_q                 <= '0;
      tiles_q             <= '0;
      kkc_q               <= '0;
      err                 <= 1'b0;
      buffer_col_nums     <= '0;
      buffer_row_nums     <= '0;
      img2col_w_width     <= '0;
      kernel_nums_rem     <= '0;
      img2col_w_width_rem <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          k_q     <= kernel_size;
          c_q     <= channels;
          n_q     <= kernel_nums;
          tiles_q <= img_tiles;
          err     <= 1'b0;
        end
        CALC1: kkc_q <= PW'(k_q) * PW'(k_q) * PW'(c_q);
        CALC2: begin
          img2col_w_width     <= kkc_q;
          buffer_col_nums     <= (kkc_q >> RW) + PW'(|kkc_q[RW-1:0]);
          buffer_row_nums     <= (n_q >> RW) + NW'(|n_q[RW-1:0]);
          kernel_nums_rem     <= n_q[RW-1:0] - RW'(1);
          img2col_w_width_rem <= kkc_q[RW-1:0] - RW'(1);
          err                 <= cfg_zero;
        end
        default: ;
      endcase
    end
  end

  // Nested counters, innermost first; the final strobe returns them all to zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      elem_cnt <= '0;
      col_cnt  <= '0;
      pass_cnt <= '0;
      row_cnt  <= '0;
    end else if (addr_enable) begin
      if (!elem_max) begin
        elem_cnt <= elem_cnt + 1'b1;
      end else begin
        elem_cnt <= '0;
        if (!col_max) begin
          col_cnt <= col_cnt + 1'b1;
        end else begin
          col_cnt <= '0;
          if (!pass_max) begin
            pass_cnt <= pass_cnt + 1'b1;
          end else begin
            pass_cnt <= '0;
            row_cnt  <= row_max ? '0 : row_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
